// File: rtl/spi_mmio_ctrl_if.sv
// Processor rq/rs bus as seen by spi_mmio_ctrl: requests in, one-cycle-latency read responses out.
interface spi_mmio_ctrl_if;
    logic        rq_en;
    logic        rq_iswrite;
    logic [31:0] rq_addr;
    logic [31:0] rq_data;
    logic        rq_hit;
    logic        rs_en;
    logic [31:0] rs_data;

    modport master (
        output rq_en, rq_iswrite, rq_addr, rq_data,
        input  rq_hit, rs_en, rs_data
    );

    modport slave (
        input  rq_en, rq_iswrite, rq_addr, rq_data,
        output rq_hit, rs_en, rs_data
    );
endinterface

// File: rtl/spi_mmio_ctrl.sv
// Memory-mapped mode-0 SPI master with TX/RX byte FIFOs, programmable SCK divider and CS policy.
// Optional build macro SPI_LOOPBACK_EN: the engine samples its own spi_mosi instead of spi_miso.
module spi_mmio_ctrl #(
    parameter logic [31:0] BASE      = 32'h10024000,
    parameter int          LGTXD     = 3,
    parameter int          LGRXD     = 3,
    parameter logic [11:0] DIV_RESET = 12'd3
) (
    input  logic           clk,
    input  logic           resetn,
    spi_mmio_ctrl_if.slave bus,
    output logic           spi_clk,
    output logic           spi_cs_n,
    output logic           spi_mosi,
    input  logic           spi_miso,
    output logic           busy
);
    localparam logic [11:0] OFF_SCKDIV = 12'h000;
    localparam logic [11:0] OFF_CSMODE = 12'h018;
    localparam logic [11:0] OFF_TXDATA = 12'h048;
    localparam logic [11:0] OFF_RXDATA = 12'h04C;
    localparam logic [1:0]  CS_HOLD    = 2'd2;
    localparam logic [1:0]  CS_OFF     = 2'd3;
    localparam int          TXD        = 1 << LGTXD;
    localparam int          RXD        = 1 << LGRXD;
    localparam logic [LGTXD:0] TX_FULL_CNT = (LGTXD+1)'(TXD);
    localparam logic [LGRXD:0] RX_FULL_CNT = (LGRXD+1)'(RXD);

    typedef enum logic [1:0] {S_IDLE, S_LOW, S_HIGH, S_GAP} state_t;

    logic [11:0] offset;
    logic        rd_hit;
    logic        wr_hit;
    logic [31:0] rd_data;
    logic        unused_wdata;

    assign bus.rq_hit   = (bus.rq_addr[31:12] == BASE[31:12]);
    assign offset       = bus.rq_addr[11:0];
    assign rd_hit       = bus.rq_en && bus.rq_hit && !bus.rq_iswrite;
    assign wr_hit       = bus.rq_en && bus.rq_hit && bus.rq_iswrite;
    assign unused_wdata = ^bus.rq_data[31:12];

    logic [11:0] sckdiv;
    logic [1:0]  csmode;
    logic [1:0]  csmode_eff;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            sckdiv <= DIV_RESET;
            csmode <= 2'd0;
        end else if (wr_hit) begin
            if (offset == OFF_SCKDIV) sckdiv <= bus.rq_data[11:0];
            if (offset == OFF_CSMODE) csmode <= bus.rq_data[1:0];
        end
    end

    // An idle HOLD link releases CS on the edge that commits a new mode.
    assign csmode_eff = (wr_hit && offset == OFF_CSMODE) ? bus.rq_data[1:0] : csmode;

    logic [7:0]       tx_mem [TXD];
    logic [LGTXD-1:0] tx_wp;
    logic [LGTXD-1:0] tx_rp;
    logic [LGTXD:0]   tx_cnt;
    logic             tx_full;
    logic             tx_empty;
    logic             tx_push;
    logic             tx_pop;
    logic [7:0]       tx_head;

    assign tx_full  = (tx_cnt == TX_FULL_CNT);
    assign tx_empty = (tx_cnt == '0);
    assign tx_push  = wr_hit && (offset == OFF_TXDATA) && !tx_full;
    assign tx_head  = tx_mem[tx_rp];

    always_ff @(posedge clk) begin
        if (!resetn) begin
            tx_wp  <= '0;
            tx_rp  <= '0;
            tx_cnt <= '0;
        end else begin
            if (tx_push) tx_wp <= tx_wp + 1'b1;
            if (tx_pop)  tx_rp <= tx_rp + 1'b1;
            tx_cnt <= tx_cnt + {{LGTXD{1'b0}}, tx_push} - {{LGTXD{1'b0}}, tx_pop};
        end
    end

    always_ff @(posedge clk) begin
        if (tx_push) tx_mem[tx_wp] <= bus.rq_data[7:0];
    end

    logic [7:0]       rx_mem [RXD];
    logic [LGRXD-1:0] rx_wp;
    logic [LGRXD-1:0] rx_rp;
    logic [LGRXD:0]   rx_cnt;
    logic             rx_full;
    logic             rx_empty;
    logic             rx_push;
    logic             rx_pop;
    logic             byte_done;

    assign rx_full  = (rx_cnt == RX_FULL_CNT);
    assign rx_empty = (rx_cnt == '0);
    assign rx_push  = byte_done && !rx_full;
    assign rx_pop   = rd_hit && (offset == OFF_RXDATA) && !rx_empty;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            rx_wp  <= '0;
            rx_rp  <= '0;
            rx_cnt <= '0;
        end else begin
            if (rx_push) rx_wp <= rx_wp + 1'b1;
            if (rx_pop)  rx_rp <= rx_rp + 1'b1;
            rx_cnt <= rx_cnt + {{LGRXD{1'b0}}, rx_push} - {{LGRXD{1'b0}}, rx_pop};
        end
    end

    logic [7:0] shreg;

    always_ff @(posedge clk) begin
        if (rx_push) rx_mem[rx_wp] <= shreg;
    end

    always_comb begin
        rd_data = 32'd0;
        case (offset)
            OFF_SCKDIV: rd_data = {20'd0, sckdiv};
            OFF_CSMODE: rd_data = {30'd0, csmode};
            OFF_TXDATA: rd_data = {tx_full, 31'd0};
            OFF_RXDATA: rd_data = rx_empty ? 32'h8000_0000 : {24'd0, rx_mem[rx_rp]};
            default:    rd_data = 32'd0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            bus.rs_en   <= 1'b0;
            bus.rs_data <= 32'd0;
        end else begin
            bus.rs_en   <= rd_hit;
            bus.rs_data <= rd_hit ? rd_data : 32'd0;
        end
    end

    logic sample_bit;
`ifdef SPI_LOOPBACK_EN
    logic unused_miso;
    assign unused_miso = spi_miso;
    assign sample_bit  = spi_mosi;
`else
    assign sample_bit  = spi_miso;
`endif

    state_t      state;
    state_t      state_n;
    logic [11:0] cnt;
    logic [11:0] cnt_n;
    logic [2:0]  bitn;
    logic [2:0]  bitn_n;
    logic [7:0]  shreg_n;
    logic        sck_n;
    logic        cs_n_n;
    logic        mosi_n;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state    <= S_IDLE;
            cnt      <= 12'd0;
            bitn     <= 3'd0;
            spi_clk  <= 1'b0;
            spi_cs_n <= 1'b1;
            spi_mosi <= 1'b0;
        end else begin
            state    <= state_n;
            cnt      <= cnt_n;
            bitn     <= bitn_n;
            spi_clk  <= sck_n;
            spi_cs_n <= cs_n_n;
            spi_mosi <= mosi_n;
        end
    end

    always_ff @(posedge clk) begin
        shreg <= shreg_n;
    end

    // Each SCK phase lasts sckdiv+1 cycles; received bits enter shreg on the rising edge.
    always_comb begin
        state_n   = state;
        cnt_n     = cnt;
        bitn_n    = bitn;
        shreg_n   = shreg;
        sck_n     = spi_clk;
        cs_n_n    = spi_cs_n;
        mosi_n    = spi_mosi;
        tx_pop    = 1'b0;
        byte_done = 1'b0;
        case (state)
            S_IDLE: begin
                if (!tx_empty) begin
                    tx_pop  = 1'b1;
                    shreg_n = tx_head;
                    mosi_n  = tx_head[7];
                    cs_n_n  = (csmode == CS_OFF);
                    cnt_n   = sckdiv;
                    bitn_n  = 3'd0;
                    state_n = S_LOW;
                end else if (csmode_eff != CS_HOLD) begin
                    cs_n_n = 1'b1;
                end
            end
            S_LOW: begin
                if (cnt != 12'd0) begin
                    cnt_n = cnt - 12'd1;
                end else begin
                    sck_n   = 1'b1;
                    shreg_n = {shreg[6:0], sample_bit};
                    cnt_n   = sckdiv;
                    state_n = S_HIGH;
                end
            end
            S_HIGH: begin
                if (cnt != 12'd0) begin
                    cnt_n = cnt - 12'd1;
                end else begin
                    sck_n = 1'b0;
                    if (bitn == 3'd7) begin
                        byte_done = 1'b1;
                        if (csmode == CS_HOLD) begin
                            state_n = S_IDLE;
                        end else begin
                            cs_n_n  = 1'b1;
                            cnt_n   = sckdiv;
                            state_n = S_GAP;
                        end
                    end else begin
                        mosi_n  = shreg[7];
                        bitn_n  = bitn + 3'd1;
                        cnt_n   = sckdiv;
                        state_n = S_LOW;
                    end
                end
            end
            S_GAP: begin
                if (cnt != 12'd0) cnt_n = cnt - 12'd1;
                else              state_n = S_IDLE;
            end
            default: state_n = S_IDLE;
        endcase
    end

    assign busy = (state != S_IDLE) || !tx_empty;

endmodule

// File: tb/tb_spi_mmio_ctrl.sv
// Self-checking bench for spi_mmio_ctrl: bus-level stimulus against a byte/bit-queue model of the SPI link.
module tb_spi_mmio_ctrl;
    localparam logic [31:0] BASE  = 32'h10024000;
    localparam logic [31:0] A_DIV = BASE + 32'h00;
    localparam logic [31:0] A_CS  = BASE + 32'h18;
    localparam logic [31:0] A_TX  = BASE + 32'h48;
    localparam logic [31:0] A_RX  = BASE + 32'h4C;
    localparam logic [31:0] EMPTY = 32'h8000_0000;
`ifdef SPI_LOOPBACK_EN
    localparam bit LOOPBACK = 1'b1;
`else
    localparam bit LOOPBACK = 1'b0;
`endif

    logic clk = 1'b0;
    logic resetn = 1'b0;
    logic spi_clk, spi_cs_n, spi_mosi, spi_miso, busy;

    spi_mmio_ctrl_if bus();

    spi_mmio_ctrl dut (
        .clk      (clk),
        .resetn   (resetn),
        .bus      (bus),
        .spi_clk  (spi_clk),
        .spi_cs_n (spi_cs_n),
        .spi_mosi (spi_mosi),
        .spi_miso (spi_miso),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Link model: every SCK rising edge records the mosi bit and CS level seen by a slave.
    bit mosi_bits[$];
    bit cs_bits[$];
    always @(posedge spi_clk) begin
        mosi_bits.push_back(spi_mosi);
        cs_bits.push_back(spi_cs_n);
    end

    // Slave answers byte k of slave_bytes MSB first, counting SCK rises from slave_base.
    logic [7:0] slave_bytes[$];
    int  slave_base = 0;
    bit  miso_const_mode = 1'b1;
    bit  miso_const = 1'b0;
    int  miso_idx;
    always @(negedge clk) begin
        miso_idx = mosi_bits.size() - slave_base;
        if (miso_const_mode)
            spi_miso = miso_const;
        else if (miso_idx >= 0 && (miso_idx / 8) < slave_bytes.size())
            spi_miso = slave_bytes[miso_idx / 8][7 - (miso_idx % 8)];
        else
            spi_miso = 1'b0;
    end

    function automatic logic [7:0] mosi_byte(input int base);
        logic [7:0] b;
        b = 8'd0;
        for (int i = 0; i < 8; i++)
            if (base + i < mosi_bits.size()) b[7 - i] = mosi_bits[base + i];
        return b;
    endfunction

    task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
        @(negedge clk);
        bus.rq_en = 1'b1; bus.rq_iswrite = 1'b1; bus.rq_addr = a; bus.rq_data = d;
        @(negedge clk);
        bus.rq_en = 1'b0; bus.rq_iswrite = 1'b0;
    endtask

    task automatic bus_read(input logic [31:0] a, output logic [31:0] d,
                            output logic pre, output logic at, output logic post);
        @(negedge clk);
        bus.rq_en = 1'b1; bus.rq_iswrite = 1'b0; bus.rq_addr = a;
        #1 pre = bus.rs_en;
        @(negedge clk);
        at = bus.rs_en; d = bus.rs_data;
        bus.rq_en = 1'b0;
        @(negedge clk);
        post = bus.rs_en;
    endtask

    task automatic wait_idle(input int maxc, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < maxc; i++) begin
            @(negedge clk);
            if (!busy) begin ok = 1'b1; break; end
        end
    endtask

    task automatic use_slave(input int n, output logic [7:0] bytes_out[$]);
        slave_bytes.delete();
        for (int i = 0; i < n; i++) slave_bytes.push_back(8'($urandom));
        slave_base = mosi_bits.size();
        miso_const_mode = 1'b0;
        bytes_out = slave_bytes;
    endtask

    task automatic test_reset();
        logic [31:0] d; logic pre, at, post;
        logic [31:0] addrs [4];
        logic [31:0] exps  [4];
        addrs = '{A_DIV, A_CS, A_TX, A_RX};
        exps  = '{32'd3, 32'd0, 32'd0, EMPTY};
        resetn = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if ({spi_clk, spi_cs_n, spi_mosi, busy, bus.rs_en} !== 5'b01000 || bus.rs_data !== 32'd0) begin
            errors++;
            $display("FAIL reset_pins got clk/cs/mosi/busy/rs_en=%b rs_data=%h want 01000 00000000",
                     {spi_clk, spi_cs_n, spi_mosi, busy, bus.rs_en}, bus.rs_data);
        end
        resetn = 1'b1;
        for (int i = 0; i < 4; i++) begin
            bus_read(addrs[i], d, pre, at, post);
            checks++;
            if (d !== exps[i]) begin
                errors++; $display("FAIL reset_read[%0d] got %h want %h", i, d, exps[i]);
            end
            checks++;
            if ({pre, at, post} !== 3'b010) begin
                errors++; $display("FAIL reset_rs_timing[%0d] got %b want 010", i, {pre, at, post});
            end
        end
        @(negedge clk);
        bus.rq_addr = A_TX;
        #1 checks++;
        if (bus.rq_hit !== 1'b1) begin errors++; $display("FAIL hit_in got %b want 1", bus.rq_hit); end
        bus.rq_addr = 32'h10025048;
        #1 checks++;
        if (bus.rq_hit !== 1'b0) begin errors++; $display("FAIL hit_out got %b want 0", bus.rq_hit); end
        bus_read(32'h10025048, d, pre, at, post);
        checks++;
        if ({pre, at, post} !== 3'b000) begin
            errors++; $display("FAIL miss_no_rs got %b want 000", {pre, at, post});
        end
    endtask

    task automatic test_single_byte();
        logic [31:0] d; logic pre, at, post;
        logic [7:0] sb[$];
        int base, lowcnt, first, last, highcyc, pulses, csbad;
        logic prev;
        bit ok;
        bus_write(A_DIV, 32'd0);
        use_slave(1, sb);
        base = mosi_bits.size();
        bus_write(A_TX, 32'h0000_00A5);
        lowcnt = 0; first = -1; last = -1; highcyc = 0; pulses = 0; prev = spi_clk;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (!spi_cs_n) begin lowcnt++; if (first < 0) first = i; last = i; end
            if (spi_clk) highcyc++;
            if (spi_clk && !prev) pulses++;
            prev = spi_clk;
        end
        wait_idle(100, ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL single_idle got busy want idle"); end
        checks++;
        if (lowcnt !== 16 || last - first + 1 !== 16) begin
            errors++; $display("FAIL single_cs_low got %0d cycles span %0d want 16", lowcnt, last - first + 1);
        end
        checks++;
        if (pulses !== 8 || highcyc !== 8) begin
            errors++; $display("FAIL single_sck got %0d pulses %0d high want 8 8", pulses, highcyc);
        end
        checks++;
        if (mosi_bits.size() - base !== 8 || mosi_byte(base) !== 8'hA5) begin
            errors++; $display("FAIL single_mosi got %0d bits %h want 8 a5", mosi_bits.size() - base, mosi_byte(base));
        end
        csbad = 0;
        for (int i = base; i < cs_bits.size(); i++) if (cs_bits[i] !== 1'b0) csbad++;
        checks++;
        if (csbad !== 0) begin errors++; $display("FAIL single_cs_at_sck got %0d high want 0", csbad); end
        bus_read(A_RX, d, pre, at, post);
        checks++;
        if (d !== {24'd0, LOOPBACK ? 8'hA5 : sb[0]}) begin
            errors++; $display("FAIL single_rx got %h want %h", d, {24'd0, LOOPBACK ? 8'hA5 : sb[0]});
        end
        bus_read(A_RX, d, pre, at, post);
        checks++;
        if (d !== EMPTY) begin errors++; $display("FAIL single_rx_empty got %h want %h", d, EMPTY); end
    endtask

    task automatic test_tx_full();
        logic [31:0] d; logic pre, at, post;
        logic [7:0] tx[$];
        int base;
        bit ok;
        bus_write(A_DIV, 32'd100);
        miso_const_mode = 1'b1; miso_const = 1'b1;
        base = mosi_bits.size();
        for (int k = 0; k < 9; k++) begin
            tx.push_back(8'($urandom));
            bus_write(A_TX, {24'd0, tx[k]});
        end
        bus_read(A_TX, d, pre, at, post);
        checks++;
        if (d !== 32'h8000_0000) begin errors++; $display("FAIL tx_full_flag got %h want 80000000", d); end
        bus_write(A_TX, 32'h0000_005A);
        wait_idle(20000, ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL tx_full_idle got busy want idle"); end
        checks++;
        if (mosi_bits.size() - base !== 72) begin
            errors++; $display("FAIL tx_full_bits got %0d want 72", mosi_bits.size() - base);
        end
        for (int k = 0; k < 9; k++) begin
            checks++;
            if (mosi_byte(base + 8 * k) !== tx[k]) begin
                errors++; $display("FAIL tx_full_byte[%0d] got %h want %h", k, mosi_byte(base + 8 * k), tx[k]);
            end
        end
        bus_read(A_TX, d, pre, at, post);
        checks++;
        if (d !== 32'd0) begin errors++; $display("FAIL tx_drained_flag got %h want 0", d); end
        for (int k = 0; k < 9; k++) begin
            bus_read(A_RX, d, pre, at, post);
            checks++;
            if (k < 8 && d !== {24'd0, LOOPBACK ? tx[k] : 8'hFF}) begin
                errors++; $display("FAIL rx_full_read[%0d] got %h want %h", k, d, {24'd0, LOOPBACK ? tx[k] : 8'hFF});
            end else if (k == 8 && d !== EMPTY) begin
                errors++; $display("FAIL rx_full_drop got %h want %h", d, EMPTY);
            end
        end
    endtask

    task automatic test_hold();
        logic [31:0] d; logic pre, at, post;
        logic [7:0] sb[$];
        int base, rises;
        bit seen_low, ok;
        bus_write(A_DIV, 32'd1);
        bus_write(A_CS, 32'd2);
        use_slave(2, sb);
        base = mosi_bits.size();
        bus_write(A_TX, 32'h01);
        bus_write(A_TX, 32'h80);
        seen_low = 1'b0; rises = 0; ok = 1'b0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (!spi_cs_n) seen_low = 1'b1;
            else if (seen_low) rises++;
            if (!busy) begin ok = 1'b1; break; end
        end
        checks++;
        if (!ok || !seen_low || rises !== 0 || spi_cs_n !== 1'b0) begin
            errors++; $display("FAIL hold_cs got idle=%b low=%b rises=%0d cs_end=%b want 1 1 0 0", ok, seen_low, rises, spi_cs_n);
        end
        checks++;
        if (mosi_byte(base) !== 8'h01 || mosi_byte(base + 8) !== 8'h80) begin
            errors++; $display("FAIL hold_mosi got %h %h want 01 80", mosi_byte(base), mosi_byte(base + 8));
        end
        bus_write(A_CS, 32'd0);
        checks++;
        if (spi_cs_n !== 1'b1) begin errors++; $display("FAIL hold_release got %b want 1", spi_cs_n); end
        for (int k = 0; k < 2; k++) begin
            bus_read(A_RX, d, pre, at, post);
            checks++;
            if (d !== {24'd0, LOOPBACK ? (k == 0 ? 8'h01 : 8'h80) : sb[k]}) begin
                errors++; $display("FAIL hold_rx[%0d] got %h want %h", k, d, {24'd0, LOOPBACK ? (k == 0 ? 8'h01 : 8'h80) : sb[k]});
            end
        end
    endtask

    task automatic test_midframe_reset();
        logic [31:0] d; logic pre, at, post;
        int base;
        bit ok;
        bus_write(A_DIV, 32'd5);
        base = mosi_bits.size();
        bus_write(A_TX, 32'($urandom_range(0, 255)));
        ok = 1'b0;
        for (int i = 0; i < 500; i++) begin
            @(negedge clk);
            if (mosi_bits.size() - base >= 4) begin ok = 1'b1; break; end
        end
        checks++;
        if (!ok) begin errors++; $display("FAIL midreset_reach_bit3 got %0d rises want 4", mosi_bits.size() - base); end
        resetn = 1'b0;
        @(negedge clk);
        checks++;
        if ({spi_clk, spi_cs_n, busy, spi_mosi} !== 4'b0100) begin
            errors++; $display("FAIL midreset_pins got clk/cs/busy/mosi=%b want 0100", {spi_clk, spi_cs_n, busy, spi_mosi});
        end
        resetn = 1'b1;
        bus_read(A_RX, d, pre, at, post);
        checks++;
        if (d !== EMPTY) begin errors++; $display("FAIL midreset_rx got %h want %h", d, EMPTY); end
        bus_read(A_DIV, d, pre, at, post);
        checks++;
        if (d !== 32'd3) begin errors++; $display("FAIL midreset_sckdiv got %h want 3", d); end
    endtask

    task automatic test_random();
        logic [31:0] d; logic pre, at, post;
        logic [7:0] sb[$];
        logic [7:0] tx[$];
        logic [11:0] div;
        logic [1:0] mode;
        int n, base, csbad;
        bit ok;
        for (int r = 0; r < 8; r++) begin
            div  = 12'($urandom_range(0, 3));
            mode = 2'($urandom_range(0, 3));
            n    = int'($urandom_range(1, 4));
            bus_write(A_DIV, {20'd0, div});
            bus_write(A_CS, {30'd0, mode});
            use_slave(n, sb);
            base = mosi_bits.size();
            tx.delete();
            for (int k = 0; k < n; k++) begin
                tx.push_back(8'($urandom));
                bus_write(A_TX, {24'd0, tx[k]});
            end
            wait_idle(2000, ok);
            checks++;
            if (!ok || mosi_bits.size() - base !== 8 * n) begin
                errors++; $display("FAIL rand%0d_frames got idle=%b bits=%0d want 1 %0d", r, ok, mosi_bits.size() - base, 8 * n);
            end
            csbad = 0;
            for (int i = base; i < cs_bits.size(); i++) if (cs_bits[i] !== (mode == 2'd3)) csbad++;
            checks++;
            if (csbad !== 0) begin errors++; $display("FAIL rand%0d_cs mode=%0d got %0d wrong want 0", r, mode, csbad); end
            for (int k = 0; k < n; k++) begin
                checks++;
                if (mosi_byte(base + 8 * k) !== tx[k]) begin
                    errors++; $display("FAIL rand%0d_mosi[%0d] got %h want %h", r, k, mosi_byte(base + 8 * k), tx[k]);
                end
                bus_read(A_RX, d, pre, at, post);
                checks++;
                if (d !== {24'd0, LOOPBACK ? tx[k] : sb[k]} || at !== 1'b1) begin
                    errors++; $display("FAIL rand%0d_rx[%0d] got %h rs_en=%b want %h 1", r, k, d, at, {24'd0, LOOPBACK ? tx[k] : sb[k]});
                end
            end
            bus_read(A_RX, d, pre, at, post);
            checks++;
            if (d !== EMPTY) begin errors++; $display("FAIL rand%0d_rx_empty got %h want %h", r, d, EMPTY); end
            bus_read(A_CS, d, pre, at, post);
            checks++;
            if (d !== {30'd0, mode}) begin errors++; $display("FAIL rand%0d_csmode got %h want %h", r, d, {30'd0, mode}); end
        end
        bus_write(A_CS, 32'd0);
    endtask

    initial begin
        bus.rq_en = 1'b0; bus.rq_iswrite = 1'b0; bus.rq_addr = 32'd0; bus.rq_data = 32'd0;
        test_reset();
        test_single_byte();
        test_tx_full();
        test_hold();
        test_midframe_reset();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog got timeout want finish");
        $fatal(1, "watchdog");
    end
endmodule
